// File: rtl/relu_sr_arbiter.sv
// Four-requester round-robin arbiter feeding a 2-stage Q7.24 -> Q3.12 round/saturate/ReLU pipeline.
// Optional feature: define STOCH_ROUND_EN for LFSR-driven stochastic rounding (default: round half up).
module relu_sr_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req_valid,
  input  logic [127:0] req_data,
  output logic [3:0]   req_ready,
  output logic         out_valid,
  output logic [15:0]  out_data,
  output logic [1:0]   out_id,
  input  logic         out_ready,
  output logic [15:0]  sat_count,
  input  logic         sat_clr
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // Upstream req_ready never depends on anything but advance and req_valid; out_valid
  // holds with stable out_data/out_id until out_ready is seen high.

  logic        advance;
  logic        accept;
  logic        grant_any;
  logic [1:0]  grant_id;
  logic [1:0]  cand;
  logic [1:0]  ptr;

  logic        s1_valid;
  logic [31:0] s1_data;
  logic [1:0]  s1_id;
  logic [11:0] s1_rnd;

  logic [11:0] rnd;
  logic        carry;
  logic [19:0] q;
  logic        is_neg;
  logic        is_sat;
  logic [15:0] result;

  assign advance = !(out_valid && !out_ready);

  // Search starts one past the last winner so every valid requester is served in turn.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = ptr;
    cand      = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign accept    = rst_n && advance && grant_any;
  assign req_ready = accept ? (4'b0001 << grant_id) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd3;
    end else if (accept) begin
      ptr <= grant_id;
    end
  end

`ifdef STOCH_ROUND_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  assign lfsr_nxt = {lfsr[0], lfsr[15] ^ lfsr[0], lfsr[14] ^ lfsr[0], lfsr[13],
                     lfsr[12] ^ lfsr[0], lfsr[11:1]};
  assign rnd      = lfsr[11:0];

  // Steps only on accepts, so stalls and bubbles leave the sequence untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'h9FC7;
    end else if (accept) begin
      lfsr <= lfsr_nxt;
    end
  end
`else
  assign rnd = 12'h800;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= 32'h0;
      s1_id    <= 2'd0;
      s1_rnd   <= 12'h0;
    end else if (advance) begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= req_data[32*grant_id +: 32];
        s1_id   <= grant_id;
        s1_rnd  <= rnd;
      end
    end
  end

  // Only the carry out of the fraction matters; q = (data + rnd) >> 12 with 20-bit wrap.
  assign carry  = ({1'b0, s1_data[11:0]} + {1'b0, s1_rnd}) >= 13'h1000;
  assign q      = s1_data[31:12] + {19'h0, carry};
  assign is_neg = q[19];
  assign is_sat = !q[19] && (|q[18:15]);

  always_comb begin
    result = q[15:0];
    if (is_neg) begin
      result = 16'h0000;
    end else if (is_sat) begin
      result = 16'h7FFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0;
      out_id    <= 2'd0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= result;
        out_id   <= s1_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= 16'h0;
    end else if (sat_clr) begin
      sat_count <= 16'h0;
    end else if (advance && s1_valid && is_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_relu_sr_arbiter.sv
// Scoreboard bench for relu_sr_arbiter: reference model of grant, rounding, LFSR and saturation count.
// Honours STOCH_ROUND_EN the same way the design does.
module tb_relu_sr_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid = 4'h0;
  logic [127:0] req_data = 128'h0;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [15:0]  out_data;
  logic [1:0]   out_id;
  logic         out_ready = 1'b1;
  logic [15:0]  sat_count;
  logic         sat_clr = 1'b0;

  relu_sr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready), .sat_count(sat_count), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [17:0] exp_q[$];
  logic [1:0]  m_ptr;
  logic [15:0] m_lfsr;
  logic        m_s1_valid;
  logic        m_s1_sat;
  logic        m_out_valid;
  logic [15:0] m_sat;
  logic [15:0] last_data;
  logic [1:0]  last_id;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_relu(input logic [31:0] x, input logic [11:0] r,
                                             output logic sat);
    logic [31:0] s;
    int q;
    s   = x + {20'h0, r};
    q   = $signed(s[31:12]);
    sat = 1'b0;
    if (q < 0) return 16'h0000;
    if (q > 32767) begin
      sat = 1'b1;
      return 16'h7FFF;
    end
    return q[15:0];
  endfunction

  function automatic logic [15:0] model_lfsr(input logic [15:0] l);
    logic [15:0] n;
    for (int i = 0; i < 16; i++) n[i] = (i == 15) ? l[0] : l[i+1];
    n[14] = n[14] ^ l[0];
    n[13] = n[13] ^ l[0];
    n[11] = n[11] ^ l[0];
    return n;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return $urandom_range(0, 32'h07FF_FFFF);
      2:       return 32'h0800_0000 + $urandom_range(0, 32'h00FF_FFFF);
      default: return $urandom_range(0, 32'h0000_1FFF);
    endcase
  endfunction

  task automatic clear_model();
    exp_q.delete();
    m_ptr       = 2'd3;
    m_lfsr      = 16'h9FC7;
    m_s1_valid  = 1'b0;
    m_s1_sat    = 1'b0;
    m_out_valid = 1'b0;
    m_sat       = 16'h0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model to the next rising edge.
  task automatic step();
    logic        adv;
    logic        found;
    logic [1:0]  g;
    logic [1:0]  c;
    logic [3:0]  exp_ready;
    logic [11:0] r;
    logic        sat;
    logic [15:0] d;
    logic [17:0] e;
    @(negedge clk);
    adv   = !(m_out_valid && !out_ready);
    found = 1'b0;
    g     = m_ptr;
    for (int k = 1; k <= 4; k++) begin
      c = m_ptr + 2'(k);
      if (!found && req_valid[c]) begin
        found = 1'b1;
        g     = c;
      end
    end
    found     = found && adv;
    exp_ready = found ? (4'b0001 << g) : 4'b0000;
    check("req_ready", {28'h0, req_ready}, {28'h0, exp_ready});
    check("out_valid", {31'h0, out_valid}, {31'h0, m_out_valid});
    if (m_out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard: got unexpected result %0h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", {16'h0, out_data}, {16'h0, e[15:0]});
        check("out_id", {30'h0, out_id}, {30'h0, e[17:16]});
        last_data = out_data;
        last_id   = out_id;
      end
    end
    check("sat_count", {16'h0, sat_count}, {16'h0, m_sat});
    if (sat_clr) m_sat = 16'h0;
    else if (adv && m_s1_valid && m_s1_sat && m_sat != 16'hFFFF) m_sat = m_sat + 16'd1;
    if (adv) begin
      m_out_valid = m_s1_valid;
      m_s1_valid  = found;
      if (found) begin
`ifdef STOCH_ROUND_EN
        r      = m_lfsr[11:0];
        m_lfsr = model_lfsr(m_lfsr);
`else
        r = 12'h800;
`endif
        d = model_relu(req_data[32*g +: 32], r, sat);
        exp_q.push_back({g, d});
        m_s1_sat = sat;
        m_ptr    = g;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_req_ready", {28'h0, req_ready}, 32'h0);
    check("rst_sat_count", {16'h0, sat_count}, 32'h0);
    clear_model();
    @(posedge clk);
    #1;
    check("rst_hold_ready", {28'h0, req_ready}, 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic send(input int id, input logic [31:0] val);
    req_valid = 4'b0001 << id;
    req_data  = 128'h0;
    req_data[32*id +: 32] = val;
    step();
    req_valid = 4'h0;
    step();
    step();
  endtask

  initial begin
    logic [15:0] hold;
    rst_n = 1'b0;
    do_reset();

`ifdef STOCH_ROUND_EN
    send(0, 32'h0000_0039);
    check("stoch_first_39", {16'h0, last_data}, 32'h0001);
    do_reset();
    send(0, 32'h0000_0038);
    check("stoch_first_38", {16'h0, last_data}, 32'h0000);
`else
    send(0, 32'h0000_0800);
    check("half_up_800", {16'h0, last_data}, 32'h0001);
`endif

    send(0, 32'h0100_0000);
    check("one_data", {16'h0, last_data}, 32'h1000);
    check("one_id", {30'h0, last_id}, 32'h0);
    check("one_sat", {16'h0, sat_count}, 32'h0);
    send(2, 32'h0900_0000);
    check("nine_data", {16'h0, last_data}, 32'h7FFF);
    check("nine_sat", {16'h0, sat_count}, 32'h1);
    send(3, 32'hFF00_0000);
    check("neg_data", {16'h0, last_data}, 32'h0000);
    check("neg_sat", {16'h0, sat_count}, 32'h1);

    // Saturating increment and clear land on the same edge: clear wins.
    req_valid = 4'b0010;
    req_data  = {32'h0, 32'h0, 32'h0900_0000, 32'h0};
    step();
    req_valid = 4'h0;
    sat_clr   = 1'b1;
    step();
    sat_clr = 1'b0;
    step();
    check("clr_priority", {16'h0, sat_count}, 32'h0);

    // All requesters active: round robin from requester 0.
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 4; j++) req_data[32*j +: 32] = rand_operand();
      step();
    end
    out_ready = 1'b0;
    hold = out_data;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", {16'h0, out_data}, {16'h0, hold});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Reset with both stages full; nothing stale may come out.
    do_reset();
    #2;
    check("grant_after_reset", {28'h0, req_ready}, 32'h1);
    for (int i = 0; i < 4; i++) step();

    for (int i = 0; i < 300; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int j = 0; j < 4; j++) req_data[32*j +: 32] = rand_operand();
      out_ready = ($urandom_range(0, 3) != 0);
      sat_clr   = ($urandom_range(0, 49) == 0);
      step();
    end

    req_valid = 4'h0;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("drain_empty", exp_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
